// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
// Captures bytes from an upstream UART receiver into a DEPTH-entry FIFO.
// Each stored entry holds the byte and the parity error flag that came with it.
// A three-state capture FSM makes exactly one write attempt per receiver byte.
// It acknowledges the byte with a one-cycle rdy_clr pulse and then waits for
// the receiver to drop rx_ready before it accepts another byte.
//
// Ports
//   CLOCK_50  in   single clock, rising edge
//   KEY0      in   asynchronous active-low reset
//   rx_data   in   [7:0] byte from receiver, valid while rx_ready=1
//   rx_ready  in   receiver byte-available level
//   rx_perr   in   parity error flag for rx_data
//   rdy_clr   out  one-cycle pulse clearing the receiver's rx_ready
//   rd_en     in   consumer read request
//   rd_data   out  [7:0] last popped byte (held between reads)
//   rd_perr   out  parity flag of the last popped byte
//   rd_valid  out  one-cycle pulse, the cycle after an accepted read
//   empty     out  count == 0
//   full      out  count == DEPTH
//   count     out  [AW:0] current occupancy
//   overflow  out  sticky flag, set when a byte is dropped
//   ovf_clr   in   synchronous clear for overflow (a same-edge drop wins)
module uart_rx_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          CLOCK_50,
  input  logic          KEY0,
  input  logic [7:0]    rx_data,
  input  logic          rx_ready,
  input  logic          rx_perr,
  output logic          rdy_clr,
  input  logic          rd_en,
  output logic [7:0]    rd_data,
  output logic          rd_perr,
  output logic          rd_valid,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   count,
  output logic          overflow,
  input  logic          ovf_clr
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    WAIT_LOW
  } state_t;

  state_t state;
  state_t state_next;

  logic [8:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  logic wr_try;
  logic rd_acc;
  logic room;
  logic wr_do;
  logic drop;

  // Capture FSM state register.
  always_ff @(posedge CLOCK_50 or negedge KEY0) begin
    if (!KEY0) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // The FSM attempts a write only when it sees rx_ready in IDLE. It then
  // sits in WAIT_LOW until the receiver drops rx_ready. This way a byte that
  // is held high for many cycles still produces only one write attempt.
  always_comb begin
    state_next = state;
    rdy_clr    = 1'b0;
    wr_try     = 1'b0;
    case (state)
      IDLE: begin
        if (rx_ready) begin
          wr_try     = 1'b1;
          state_next = CLEAR;
        end
      end
      CLEAR: begin
        rdy_clr    = 1'b1;
        state_next = WAIT_LOW;
      end
      WAIT_LOW: begin
        if (!rx_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // When the FIFO is full, a read accepted on the same edge frees a slot,
  // so the incoming byte is kept rather than dropped. A dropped byte still
  // receives its rdy_clr acknowledge through the normal FSM path.
  assign empty  = (count == '0);
  assign full   = (count == DEPTH_C);
  assign rd_acc = rd_en && !empty;
  assign room   = (count < DEPTH_C) || rd_acc;
  assign wr_do  = wr_try && room;
  assign drop   = wr_try && !room;

  // Storage array. It has no reset, because contents are only meaningful
  // through the pointers and count.
  always_ff @(posedge CLOCK_50) begin
    if (wr_do) begin
      mem[wr_ptr] <= {rx_perr, rx_data};
    end
  end

  // Pointers and occupancy. Both pointers wrap because DEPTH is a power of two.
  always_ff @(posedge CLOCK_50 or negedge KEY0) begin
    if (!KEY0) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_do) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({wr_do, rd_acc})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Read port. The output registers load only on an accepted read, so they
  // keep the last popped entry between reads.
  always_ff @(posedge CLOCK_50 or negedge KEY0) begin
    if (!KEY0) begin
      rd_data  <= 8'h00;
      rd_perr  <= 1'b0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_acc;
      if (rd_acc) begin
        {rd_perr, rd_data} <= mem[rd_ptr];
      end
    end
  end

  // Sticky overflow flag. A drop on the same edge as ovf_clr keeps the flag set.
  always_ff @(posedge CLOCK_50 or negedge KEY0) begin
    if (!KEY0) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo
// Bench for uart_rx_fifo. It plays the upstream receiver and the downstream
// consumer. A queue-based model tracks FIFO contents, occupancy, the sticky
// overflow flag and the expected read outputs, and every output is compared
// at each falling edge.
module tb_uart_rx_fifo;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          CLOCK_50;
  logic          KEY0;
  logic [7:0]    rx_data;
  logic          rx_ready;
  logic          rx_perr;
  logic          rdy_clr;
  logic          rd_en;
  logic [7:0]    rd_data;
  logic          rd_perr;
  logic          rd_valid;
  logic          empty;
  logic          full;
  logic [AW:0]   count;
  logic          overflow;
  logic          ovf_clr;

  uart_rx_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
    .CLOCK_50 (CLOCK_50),
    .KEY0     (KEY0),
    .rx_data  (rx_data),
    .rx_ready (rx_ready),
    .rx_perr  (rx_perr),
    .rdy_clr  (rdy_clr),
    .rd_en    (rd_en),
    .rd_data  (rd_data),
    .rd_perr  (rd_perr),
    .rd_valid (rd_valid),
    .empty    (empty),
    .full     (full),
    .count    (count),
    .overflow (overflow),
    .ovf_clr  (ovf_clr)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  // Reference model state
  logic [8:0] q[$];
  logic       ovf_m;
  logic [7:0] exp_data;
  logic       exp_perr;
  logic       exp_valid;
  logic       exp_rdy;
  bit         pending;
  bit         rand_mode;
  int         pulses;
  int         total;
  int         bad;
  string      phase;

  // One comparison: counts it and reports any difference.
  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compares every DUT output against the model.
  task automatic check_all();
    check_output({phase, ":count"},    32'(count),    32'(q.size()));
    check_output({phase, ":empty"},    32'(empty),    32'(q.size() == 0));
    check_output({phase, ":full"},     32'(full),     32'(q.size() == DEPTH));
    check_output({phase, ":overflow"}, 32'(overflow), 32'(ovf_m));
    check_output({phase, ":rd_valid"}, 32'(rd_valid), 32'(exp_valid));
    check_output({phase, ":rdy_clr"},  32'(rdy_clr),  32'(exp_rdy));
    check_output({phase, ":rd_data"},  32'(rd_data),  32'(exp_data));
    check_output({phase, ":rd_perr"},  32'(rd_perr),  32'(exp_perr));
  endtask

  task automatic model_reset();
    q.delete();
    ovf_m     = 1'b0;
    exp_data  = 8'h00;
    exp_perr  = 1'b0;
    exp_valid = 1'b0;
    exp_rdy   = 1'b0;
  endtask

  // Advance one clock. The model is updated for the coming rising edge, and
  // the outputs are checked at the following falling edge.
  task automatic tick();
    logic       rd_acc;
    logic       drop;
    logic [8:0] e;
    if (rand_mode) begin
      rd_en   = 1'($urandom_range(0, 1));
      ovf_clr = ($urandom_range(0, 7) == 0);
    end
    drop      = 1'b0;
    exp_rdy   = 1'b0;
    rd_acc    = rd_en && (q.size() != 0);
    exp_valid = rd_acc;
    if (rd_acc) begin
      e        = q.pop_front();
      exp_perr = e[8];
      exp_data = e[7:0];
    end
    if (pending && rx_ready) begin
      pending = 0;
      exp_rdy = 1'b1;
      if (q.size() < DEPTH) q.push_back({rx_perr, rx_data});
      else drop = 1'b1;
    end
    if (drop) ovf_m = 1'b1;
    else if (ovf_clr) ovf_m = 1'b0;
    @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    if (rdy_clr === 1'b1) pulses++;
    check_all();
  endtask

  // Receiver side: present one byte for 'hold' cycles, then keep rx_ready
  // low for two cycles so the next byte is seen as new.
  task automatic apply_stimulus(input logic [7:0] d, input logic p, input int hold, input logic rd_first);
    rx_data  = d;
    rx_perr  = p;
    rx_ready = 1'b1;
    pending  = 1;
    rd_en    = rd_first;
    tick();
    rd_en = 1'b0;
    for (int i = 1; i < hold; i++) tick();
    rx_ready = 1'b0;
    tick();
    tick();
  endtask

  task automatic read_byte();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  initial begin
    total = 0; bad = 0; pulses = 0;
    pending = 0; rand_mode = 0;
    KEY0 = 1'b0; rx_data = 8'h00; rx_ready = 1'b0; rx_perr = 1'b0;
    rd_en = 1'b0; ovf_clr = 1'b0;
    model_reset();

    // Reset state
    phase = "reset";
    #2;
    check_all();
    @(negedge CLOCK_50);
    @(negedge CLOCK_50);
    KEY0 = 1'b1;
    tick();

    // Single byte held high for ten cycles
    phase = "single";
    pulses = 0;
    apply_stimulus(8'h09, 1'b0, 10, 1'b0);
    check_output("single:pulses", 32'(pulses), 32'd1);
    read_byte();
    tick();

    // Fill to full, then drop the 17th byte
    phase = "fill";
    pulses = 0;
    for (int i = 0; i < 17; i++) apply_stimulus(8'(i), 1'b0, 2, 1'b0);
    check_output("fill:pulses", 32'(pulses), 32'd17);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    phase = "drain";
    for (int i = 0; i < 16; i++) begin
      read_byte();
      check_output("drain:order", 32'(rd_data), 32'(i));
    end
    read_byte();

    // Full with a read on the capture edge
    phase = "fullrw";
    for (int i = 0; i < 16; i++) apply_stimulus(8'($urandom), 1'($urandom_range(0, 1)), 1, 1'b0);
    apply_stimulus(8'hA5, 1'b0, 2, 1'b1);
    for (int i = 0; i < 16; i++) read_byte();
    check_output("fullrw:last", 32'(rd_data), 32'hA5);

    // Parity propagation
    phase = "parity";
    apply_stimulus(8'h3C, 1'b1, 3, 1'b0);
    read_byte();
    check_output("parity:perr", 32'(rd_perr), 32'd1);

    // Forty write/read pairs to exercise pointer wrap
    phase = "wrap";
    for (int i = 0; i < 40; i++) begin
      apply_stimulus(8'(8'h40 + i), 1'b0, 2, 1'b0);
      read_byte();
      check_output("wrap:order", 32'(rd_data), 32'(8'h40 + i));
    end
    check_output("wrap:count", 32'(count), 32'd0);

    // Randomized traffic with random reads and overflow clears
    phase = "random";
    rand_mode = 1;
    for (int i = 0; i < 80; i++) apply_stimulus(8'($urandom), 1'($urandom_range(0, 1)), $urandom_range(1, 4), 1'b0);
    rand_mode = 0;
    rd_en = 1'b0;
    ovf_clr = 1'b0;
    for (int i = 0; i < 20; i++) read_byte();

    // Reset in the middle of a handshake
    phase = "midrst";
    for (int i = 0; i < 4; i++) apply_stimulus(8'(8'h60 + i), 1'b0, 2, 1'b0);
    rx_data = 8'h64; rx_perr = 1'b0; rx_ready = 1'b1; pending = 1;
    tick();
    tick();
    tick();
    rx_data = 8'h77;
    #2;
    KEY0 = 1'b0;
    #1;
    model_reset();
    pending = 1;
    phase = "midrst_async";
    check_all();
    @(negedge CLOCK_50);
    KEY0 = 1'b1;
    phase = "midrst_rel";
    tick();
    check_output("midrst:count", 32'(count), 32'd1);
    rx_ready = 1'b0;
    tick();
    tick();
    read_byte();
    check_output("midrst:data", 32'(rd_data), 32'h77);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameter DEPTH, default 16, FIFO entry count; SHALL be a power of two, 2..256.
REQ-002 Parameter AW, default 4, pointer width; SHALL equal log2(DEPTH).
REQ-003 CLOCK_50  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 KEY0  input  1  reset; SHALL be asynchronous, active-low.
REQ-005 rx_data  input  8  byte from the upstream UART receiver, valid while rx_ready=1.
REQ-006 rx_ready  input  1  receiver byte-available level, held high until cleared.
REQ-007 rx_perr  input  1  parity error flag for rx_data, valid while rx_ready=1.
REQ-008 rdy_clr  output  1  one-cycle pulse that clears the receiver's rx_ready.
REQ-009 rd_en  input  1  consumer read request.
REQ-010 rd_data  output  8  popped byte.
REQ-011 rd_perr  output  1  parity flag stored with the popped byte.
REQ-012 rd_valid  output  1  one-cycle pulse qualifying rd_data and rd_perr.
REQ-013 empty / full  output  1 each  FIFO status, combinational from count.
REQ-014 count  output  AW+1  current occupancy, 0..DEPTH.
REQ-015 overflow  output  1  sticky flag set when a byte is dropped.
REQ-016 ovf_clr  input  1  synchronous clear for overflow.

Function
REQ-017 The capture FSM SHALL have the states IDLE, CLEAR and WAIT_LOW.
REQ-018 IDLE with rx_ready=1: the FSM SHALL write {rx_perr,rx_data} on that edge if it has room, then go to CLEAR.
REQ-019 CLEAR: rdy_clr=1 for exactly one cycle, then go to WAIT_LOW.
REQ-020 WAIT_LOW: rdy_clr=0 and no write; the FSM SHALL return to IDLE on the first cycle rx_ready=0.
REQ-021 Each receiver byte SHALL produce exactly one write attempt, however long rx_ready stays high.
REQ-022 Room: a write has room when count<DEPTH, or when count=DEPTH and an accepted read occurs on the same edge.
REQ-023 A write without room SHALL drop the byte, set overflow, and still issue rdy_clr.
REQ-024 A read is accepted when rd_en=1 and empty=0; rd_data/rd_perr SHALL be registered on that edge, with rd_valid=1 the following cycle (latency 1).
REQ-025 rd_en while empty SHALL be ignored: no pointer change and no rd_valid; there is no fall-through of a same-cycle write.
REQ-026 rd_data and rd_perr SHALL hold their last popped values between reads.
REQ-027 Simultaneous accepted read and write: count SHALL be unchanged and both pointers SHALL advance.
REQ-028 Pointers SHALL wrap modulo DEPTH; count SHALL never exceed DEPTH or go below 0.
REQ-029 empty = (count==0); full = (count==DEPTH).
REQ-030 ovf_clr=1 SHALL clear overflow; if a drop occurs on the same edge, overflow SHALL remain 1 (set wins).

Reset
REQ-031 KEY0=0 SHALL immediately force: FSM=IDLE, pointers=0, count=0, rdy_clr=0, rd_valid=0, rd_data=8'h00, rd_perr=0, overflow=0, empty=1, full=0.
REQ-032 Reset mid-handshake SHALL abandon the FIFO contents; if rx_ready=1 after release, the byte SHALL be captured as new.
REQ-033 Reset release SHALL take effect on the first CLOCK_50 edge after KEY0 returns to 1.

Verification
REQ-034 Single byte: rx_data=8'h09, rx_perr=0, rx_ready held high 10 cycles -> one rdy_clr pulse, count=1; rd_en -> rd_valid next cycle, rd_data=8'h09, empty=1.
REQ-035 Fill and overflow: 17 bytes 8'h00..8'h10 with DEPTH=16 -> full=1 after the 16th, the 17th dropped, overflow=1, 17 rdy_clr pulses; 16 reads return 8'h00..8'h0F in order.
REQ-036 Full with simultaneous read and write: count=16, rd_en on the capture edge of 8'hA5 -> count stays 16, 8'hA5 stored, overflow=0.
REQ-037 Parity propagation: rx_perr=1 with 8'h3C -> the read returns rd_data=8'h3C, rd_perr=1.
REQ-038 Wrap: 40 write/read pairs of incrementing bytes -> all 40 returned in order, count returns to 0.
REQ-039 Reset mid-operation: count=5 and FSM in WAIT_LOW, pulse KEY0 low -> all outputs at reset values at once; held rx_ready=1 with 8'h77 -> captured, count=1.
